// File: rtl/gb_sound_pkg.sv
// Shared constants, config addresses and FSM states
// for the stereo sound mix sequencer.
package gb_sound_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] ADDR_NR51 = 2'd0;
  localparam logic [1:0] ADDR_NR50 = 2'd1;
  localparam logic [1:0] ADDR_NR52 = 2'd2;

  localparam int NR50_R_LSB  = 0;
  localparam int NR50_L_LSB  = 4;
  localparam int NR51_L_OFS  = 4;
  localparam int NR52_EN_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SCALE,
    OUT
  } mix_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Wrapping sample-period counter; tick marks
// the last clock of each period.
module sample_tick_gen #(
  parameter int SAMPLE_TIME = 128
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_TIME);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(SAMPLE_TIME - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sound_mix_sequencer.sv
// Per-sample stereo mixer: snapshots channels on tick,
// accumulates one channel per cycle, scales by volume.
module sound_mix_sequencer
  import gb_sound_pkg::*;
#(
  parameter int SAMPLE_TIME = 128,
  parameter int CH_W        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] ch_in,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [7:0]             cfg_wdata,
  output logic [CH_W-1:0]        left,
  output logic [CH_W-1:0]        right,
  output logic                   out_valid
);

  localparam int AW = CH_W + 2;
  localparam int PW = CH_W + 5;

  if (SAMPLE_TIME < 8) begin : g_bad_period
    $error("SAMPLE_TIME must be >= 8");
  end

  logic tick;

  sample_tick_gen #(
    .SAMPLE_TIME(SAMPLE_TIME)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  mix_state_e state_q, state_d;

  logic [7:0] pan_sh_q, pan_sh_d, pan_q, pan_d;
  logic [2:0] vl_sh_q, vl_sh_d, vl_q, vl_d;
  logic [2:0] vr_sh_q, vr_sh_d, vr_q, vr_d;
  logic       en_sh_q, en_sh_d, en_q, en_d;

  logic [NUM_CH*CH_W-1:0] snap_q, snap_d;
  logic [1:0]             idx_q, idx_d;
  logic [AW-1:0]          acc_l_q, acc_l_d;
  logic [AW-1:0]          acc_r_q, acc_r_d;
  logic [CH_W-1:0]        left_q, left_d;
  logic [CH_W-1:0]        right_q, right_d;
  logic [CH_W-1:0]        ch_cur;

  function automatic logic [CH_W-1:0] scale(
    input logic [AW-1:0] acc,
    input logic [2:0]    v
  );
    logic [PW-1:0] prod;
    prod = PW'(acc) * PW'({1'b0, v} + 4'd1);
    return prod[PW-1:5];
  endfunction

  always_comb begin
    state_d  = state_q;
    pan_sh_d = pan_sh_q;
    vl_sh_d  = vl_sh_q;
    vr_sh_d  = vr_sh_q;
    en_sh_d  = en_sh_q;
    pan_d    = pan_q;
    vl_d     = vl_q;
    vr_d     = vr_q;
    en_d     = en_q;
    snap_d   = snap_q;
    idx_d    = idx_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    left_d   = left_q;
    right_d  = right_q;
    ch_cur   = snap_q[int'(idx_q)*CH_W +: CH_W];

    if (cfg_we) begin
      case (cfg_addr)
        ADDR_NR51: pan_sh_d = cfg_wdata;
        ADDR_NR50: begin
          vr_sh_d = cfg_wdata[NR50_R_LSB +: 3];
          vl_sh_d = cfg_wdata[NR50_L_LSB +: 3];
        end
        ADDR_NR52: en_sh_d = cfg_wdata[NR52_EN_BIT];
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d  = ch_in;
          pan_d   = pan_sh_q;
          vl_d    = vl_sh_q;
          vr_d    = vr_sh_q;
          en_d    = en_sh_q;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (pan_q[int'(idx_q)])
          acc_r_d = acc_r_q + AW'(ch_cur);
        if (pan_q[NR51_L_OFS + int'(idx_q)])
          acc_l_d = acc_l_q + AW'(ch_cur);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = SCALE;
      end
      SCALE: begin
        left_d  = en_q ? scale(acc_l_q, vl_q) : '0;
        right_d = en_q ? scale(acc_r_q, vr_q) : '0;
        state_d = OUT;
      end
      OUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pan_sh_q <= '0;
      vl_sh_q  <= '0;
      vr_sh_q  <= '0;
      en_sh_q  <= 1'b0;
      pan_q    <= '0;
      vl_q     <= '0;
      vr_q     <= '0;
      en_q     <= 1'b0;
      snap_q   <= '0;
      idx_q    <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
    end else begin
      state_q  <= state_d;
      pan_sh_q <= pan_sh_d;
      vl_sh_q  <= vl_sh_d;
      vr_sh_q  <= vr_sh_d;
      en_sh_q  <= en_sh_d;
      pan_q    <= pan_d;
      vl_q     <= vl_d;
      vr_q     <= vr_d;
      en_q     <= en_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign out_valid = (state_q == OUT);

endmodule

// File: tb/tb_sound_mix_sequencer.sv
// Directed bench for sound_mix_sequencer: reset, mixing,
// volume masking, config timing, enable and mid-frame reset.
module tb_sound_mix_sequencer;

  localparam int ST   = 128;
  localparam int CH_W = 4;
  localparam int LIM  = 3 * ST;

  logic            clk;
  logic            rst_n;
  logic [15:0]     ch_in;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [7:0]      cfg_wdata;
  logic [CH_W-1:0] left;
  logic [CH_W-1:0] right;
  logic            out_valid;

  int tests_run;
  int tests_failed;

  sound_mix_sequencer #(
    .SAMPLE_TIME(ST),
    .CH_W       (CH_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_in    (ch_in),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .left     (left),
    .right    (right),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
  endtask

  // Returns at the negedge where out_valid is seen; n = posedges waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid === 1'b1) return;
      if (n >= LIM) begin
        tests_run++;
        tests_failed++;
        $display("FAIL wait_valid: no out_valid within %0d cycles", LIM);
        return;
      end
    end
  endtask

  task automatic check_lr(input string name,
                          input logic [3:0] el,
                          input logic [3:0] er);
    tests_run++;
    if (left !== el || right !== er) begin
      tests_failed++;
      $display("FAIL %s: left=%0d right=%0d expected left=%0d right=%0d",
               name, left, right, el, er);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (left !== 4'd0 || right !== 4'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: l=%0d r=%0d v=%0b expected 0 0 0",
               left, right, out_valid);
    end
    rst_n = 1'b1;
    wait_valid(n);
    tests_run++;
    if (n != ST + 5) begin
      tests_failed++;
      $display("FAIL first_valid: got %0d cycles expected %0d", n, ST + 5);
    end
    check_lr("reset_disabled_out", 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_one_cycle: got %0b expected 0", out_valid);
    end
    wait_valid(n);
    tests_run++;
    if (n != ST - 1) begin
      tests_failed++;
      $display("FAIL period: got %0d cycles expected %0d", n, ST - 1);
    end
  endtask

  task automatic test_full_scale();
    int n;
    ch_in = 16'hFFFF;
    cfg_write(2'd2, 8'h80);
    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd1, 8'h77);
    cfg_write(2'd3, 8'h00);
    wait_valid(n);
    wait_valid(n);
    check_lr("full_scale", 4'd15, 4'd15);
  endtask

  task automatic test_pan_split();
    int n;
    ch_in = 16'hFF48;
    cfg_write(2'd0, 8'h12);
    wait_valid(n);
    wait_valid(n);
    check_lr("pan_split", 4'd2, 4'd1);
  endtask

  task automatic test_vol_mask();
    int n;
    ch_in = 16'hFFFF;
    cfg_write(2'd0, 8'hFF);
    cfg_write(2'd1, 8'h07);
    wait_valid(n);
    wait_valid(n);
    check_lr("vol_07", 4'd1, 4'd15);
    cfg_write(2'd1, 8'h8F);
    wait_valid(n);
    wait_valid(n);
    check_lr("vol_8F_masked", 4'd1, 4'd15);
    cfg_write(2'd1, 8'h30);
    wait_valid(n);
    wait_valid(n);
    check_lr("vol_30", 4'd7, 4'd1);
  endtask

  task automatic test_cfg_timing();
    int n;
    cfg_write(2'd1, 8'h77);
    wait_valid(n);
    wait_valid(n);
    check_lr("timing_base", 4'd15, 4'd15);
    repeat (ST - 6) @(posedge clk);
    cfg_write(2'd0, 8'h00);
    wait_valid(n);
    check_lr("write_on_tick_old", 4'd15, 4'd15);
    wait_valid(n);
    check_lr("write_on_tick_new", 4'd0, 4'd0);
    repeat (ST - 4) @(posedge clk);
    cfg_write(2'd0, 8'hFF);
    wait_valid(n);
    check_lr("write_in_acc_old", 4'd0, 4'd0);
    wait_valid(n);
    check_lr("write_in_acc_new", 4'd15, 4'd15);
  endtask

  task automatic test_enable();
    int n;
    cfg_write(2'd2, 8'h00);
    wait_valid(n);
    wait_valid(n);
    tests_run++;
    if (n != ST) begin
      tests_failed++;
      $display("FAIL disabled_period: got %0d cycles expected %0d", n, ST);
    end
    check_lr("disabled_zero", 4'd0, 4'd0);
    cfg_write(2'd2, 8'h80);
    wait_valid(n);
    wait_valid(n);
    check_lr("reenabled", 4'd15, 4'd15);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    repeat (ST - 4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (left !== 4'd0 || right !== 4'd0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: l=%0d r=%0d v=%0b expected 0 0 0",
               left, right, out_valid);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_hold: v=%0b expected 0", out_valid);
    end
    rst_n = 1'b1;
    wait_valid(n);
    tests_run++;
    if (n != ST + 5) begin
      tests_failed++;
      $display("FAIL mid_reset_first_valid: got %0d expected %0d", n, ST + 5);
    end
    check_lr("mid_reset_cfg_cleared", 4'd0, 4'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    ch_in        = 16'h0000;
    cfg_we       = 1'b0;
    cfg_addr     = 2'd0;
    cfg_wdata    = 8'h00;
    test_reset();
    test_full_scale();
    test_pan_split();
    test_vol_mask();
    test_cfg_timing();
    test_enable();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
